// File: rtl/uart_sched.sv
// Round-robin transmit scheduler for a single UART: it arbitrates NREQ byte sources,
// paces write_tx with a guard window, pops received bytes and holds pending config until idle.
module uart_sched #(
    parameter int NREQ  = 4,
    parameter int GUARD = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NREQ-1:0]     req_valid,
    input  logic [8*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]     req_ready,
    input  logic                tx_empty,
    output logic [7:0]          txdata,
    output logic                write_tx,
    input  logic                rx_valid,
    input  logic [7:0]          rxdata,
    output logic                read_rx,
    output logic [7:0]          rx_byte,
    output logic                rx_strobe,
    output logic [1:0]          rx_owner,
    input  logic                cfg_load,
    input  logic [15:0]         baud_cfg,
    input  logic [7:0]          ctrl_cfg,
    output logic [15:0]         baudrate,
    output logic [7:0]          control,
    output logic                busy
);

    localparam int CW = (GUARD < 1) ? 1 : $clog2(GUARD + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WRITE,
        S_GUARD,
        S_DRAIN
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [1:0]      last_grant_q, last_grant_d;
    logic [1:0]      rx_owner_q, rx_owner_d;
    logic [7:0]      txdata_q, txdata_d;
    logic            read_rx_q, read_rx_d;
    logic [7:0]      rx_byte_q, rx_byte_d;
    logic            cfg_pend_q, cfg_pend_d;
    logic [15:0]     baud_pend_q, baud_pend_d;
    logic [7:0]      ctrl_pend_q, ctrl_pend_d;
    logic [15:0]     baudrate_q, baudrate_d;
    logic [7:0]      control_q, control_d;

    logic [7:0]      req_byte [NREQ];
    logic            grant_found;
    logic [1:0]      grant_idx;
    logic [1:0]      search_idx;
    logic            cfg_apply;
    logic            grant_ok;

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
        assign req_byte[gi] = req_data[8*gi +: 8];
    end

    // Rotating priority: first valid requester at or after last_grant+1.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        search_idx  = '0;
        for (int k = 0; k < NREQ; k++) begin
            search_idx = last_grant_q + 2'(k + 1);
            if (!grant_found && req_valid[search_idx]) begin
                grant_found = 1'b1;
                grant_idx   = search_idx;
            end
        end
    end

    // A config request seen in IDLE (stored or arriving now) pre-empts the grant for that cycle.
    assign cfg_apply = (state_q == S_IDLE) && (cfg_pend_q || cfg_load);
    assign grant_ok  = (state_q == S_IDLE) && tx_empty && grant_found && !cfg_apply;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        last_grant_d = last_grant_q;
        rx_owner_d   = rx_owner_q;
        txdata_d     = txdata_q;
        cfg_pend_d   = cfg_pend_q;
        baud_pend_d  = baud_pend_q;
        ctrl_pend_d  = ctrl_pend_q;
        baudrate_d   = baudrate_q;
        control_d    = control_q;

        if (cfg_load) begin
            cfg_pend_d  = 1'b1;
            baud_pend_d = baud_cfg;
            ctrl_pend_d = ctrl_cfg;
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_apply) begin
                    baudrate_d = cfg_load ? baud_cfg : baud_pend_q;
                    control_d  = cfg_load ? ctrl_cfg : ctrl_pend_q;
                    cfg_pend_d = 1'b0;
                end else if (grant_ok) begin
                    txdata_d     = req_byte[grant_idx];
                    last_grant_d = grant_idx;
                    rx_owner_d   = grant_idx;
                    state_d      = S_WRITE;
                end
            end
            S_WRITE: begin
                cnt_d   = CW'(GUARD);
                state_d = S_GUARD;
            end
            S_GUARD: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q <= CW'(1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (tx_empty) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Receive path ignores the TX state; the previous pop blocks a back-to-back pop.
    always_comb begin
        read_rx_d = rx_valid && !read_rx_q;
        rx_byte_d = read_rx_d ? rxdata : rx_byte_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            last_grant_q <= 2'd3;
            rx_owner_q   <= 2'd0;
            txdata_q     <= 8'd0;
            read_rx_q    <= 1'b0;
            rx_byte_q    <= 8'd0;
            cfg_pend_q   <= 1'b0;
            baud_pend_q  <= 16'd0;
            ctrl_pend_q  <= 8'd0;
            baudrate_q   <= 16'd0;
            control_q    <= 8'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            last_grant_q <= last_grant_d;
            rx_owner_q   <= rx_owner_d;
            txdata_q     <= txdata_d;
            read_rx_q    <= read_rx_d;
            rx_byte_q    <= rx_byte_d;
            cfg_pend_q   <= cfg_pend_d;
            baud_pend_q  <= baud_pend_d;
            ctrl_pend_q  <= ctrl_pend_d;
            baudrate_q   <= baudrate_d;
            control_q    <= control_d;
        end
    end

    // req_ready is combinational, so it is gated by rst_n to stay low throughout reset.
    assign req_ready = (grant_ok && rst_n) ? (NREQ'(1) << grant_idx) : '0;
    assign write_tx  = (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign txdata    = txdata_q;
    assign read_rx   = read_rx_q;
    assign rx_strobe = read_rx_q;
    assign rx_byte   = rx_byte_q;
    assign rx_owner  = rx_owner_q;
    assign baudrate  = baudrate_q;
    assign control   = control_q;

endmodule

// File: tb/tb_uart_sched.sv
// Directed bench for uart_sched: round-robin grants, guard pacing, RX popping,
// deferred config, asynchronous reset and request withdrawal.
module tb_uart_sched;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_ready;
    logic        tx_empty;
    logic [7:0]  txdata;
    logic        write_tx;
    logic        rx_valid;
    logic [7:0]  rxdata;
    logic        read_rx;
    logic [7:0]  rx_byte;
    logic        rx_strobe;
    logic [1:0]  rx_owner;
    logic        cfg_load;
    logic [15:0] baud_cfg;
    logic [7:0]  ctrl_cfg;
    logic [15:0] baudrate;
    logic [7:0]  control;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    uart_sched #(.NREQ(4), .GUARD(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .tx_empty  (tx_empty),
        .txdata    (txdata),
        .write_tx  (write_tx),
        .rx_valid  (rx_valid),
        .rxdata    (rxdata),
        .read_rx   (read_rx),
        .rx_byte   (rx_byte),
        .rx_strobe (rx_strobe),
        .rx_owner  (rx_owner),
        .cfg_load  (cfg_load),
        .baud_cfg  (baud_cfg),
        .ctrl_cfg  (ctrl_cfg),
        .baudrate  (baudrate),
        .control   (control),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        int o;
        logic [31:0] dw;

        rst_n     = 1'b0;
        req_valid = 4'b1111;
        req_data  = 32'h44332211;
        tx_empty  = 1'b1;
        rx_valid  = 1'b0;
        rxdata    = 8'h00;
        cfg_load  = 1'b0;
        baud_cfg  = 16'h0000;
        ctrl_cfg  = 8'h00;

        // Reset state, including req_ready gated despite a live grant opportunity.
        #3;
        chk("rst_ready", 32'(req_ready), 32'h0);
        chk("rst_write", 32'(write_tx), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_txdata", 32'(txdata), 32'h0);
        chk("rst_baud", 32'(baudrate), 32'h0);
        chk("rst_ctrl", 32'(control), 32'h0);
        chk("rst_owner", 32'(rx_owner), 32'h0);
        chk("rst_readrx", 32'(read_rx), 32'h0);
        chk("rst_rxbyte", 32'(rx_byte), 32'h0);
        tick();
        tick();
        chk("rst_hold_write", 32'(write_tx), 32'h0);
        $display("step reset: done");

        // All four requesting: grants 0,1,2,3,0 every five cycles.
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < 22; i++) begin
            o  = (i / 5) % 4;
            dw = req_data;
            chk("rr_ready", 32'(req_ready), (i % 5 == 0) ? (32'd1 << o) : 32'd0);
            chk("rr_write", 32'(write_tx), (i % 5 == 1) ? 32'd1 : 32'd0);
            chk("rr_busy", 32'(busy), (i % 5 != 0) ? 32'd1 : 32'd0);
            if (i % 5 == 1) begin
                chk("rr_txdata", 32'(txdata), 32'(dw[8*o +: 8]));
                chk("rr_owner", 32'(rx_owner), 32'(o));
            end
            if (i < 21) tick();
        end
        req_valid = 4'b0000;
        $display("step round-robin: five grants walked");

        // Single requester 2 with a slow transmitter.
        tick();
        tick();
        tick();
        tick();
        chk("a5_idle", 32'(busy), 32'h0);
        req_data  = 32'h44A52211;
        req_valid = 4'b0100;
        #1;
        chk("a5_ready", 32'(req_ready), 32'h4);
        tick();
        chk("a5_write", 32'(write_tx), 32'h1);
        chk("a5_txdata", 32'(txdata), 32'hA5);
        req_valid = 4'b0000;
        tx_empty  = 1'b0;
        for (int j = 0; j < 10; j++) begin
            tick();
            chk("a5_nowrite", 32'(write_tx), 32'h0);
            chk("a5_busy", 32'(busy), 32'h1);
            chk("a5_hold", 32'(txdata), 32'hA5);
        end
        tx_empty = 1'b1;
        tick();
        chk("a5_back_idle", 32'(busy), 32'h0);
        $display("step slow-tx: single write of a5");

        // Grant requester 1, then hold rx_valid for six cycles.
        req_valid = 4'b0010;
        #1;
        chk("rx_pre_ready", 32'(req_ready), 32'h2);
        tick();
        chk("rx_pre_write", 32'(write_tx), 32'h1);
        chk("rx_pre_txdata", 32'(txdata), 32'h22);
        chk("rx_pre_byte", 32'(rx_byte), 32'h0);
        req_valid = 4'b0000;
        rx_valid  = 1'b1;
        rxdata    = 8'h3C;
        for (int j = 1; j <= 7; j++) begin
            tick();
            chk("rx_read", 32'(read_rx), (j % 2 == 1 && j < 6) ? 32'd1 : 32'd0);
            chk("rx_strobe", 32'(rx_strobe), (j % 2 == 1 && j < 6) ? 32'd1 : 32'd0);
            chk("rx_byte", 32'(rx_byte), 32'h3C);
            if (j == 5) rx_valid = 1'b0;
        end
        chk("rx_owner", 32'(rx_owner), 32'h1);
        chk("rx_tx_idle", 32'(busy), 32'h0);
        $display("step rx: three pops of 3c");

        // Config arriving in DRAIN is held until IDLE; the later load wins.
        req_valid = 4'b0001;
        #1;
        chk("cfg_pre_ready", 32'(req_ready), 32'h1);
        tick();
        chk("cfg_pre_txdata", 32'(txdata), 32'h11);
        req_valid = 4'b0000;
        tx_empty  = 1'b0;
        tick();
        tick();
        tick();
        chk("cfg_in_drain", 32'(busy), 32'h1);
        cfg_load = 1'b1;
        baud_cfg = 16'h1111;
        ctrl_cfg = 8'h11;
        tick();
        baud_cfg = 16'h0145;
        ctrl_cfg = 8'h81;
        chk("cfg_hold_baud1", 32'(baudrate), 32'h0);
        tick();
        cfg_load = 1'b0;
        baud_cfg = 16'hFFFF;
        ctrl_cfg = 8'hFF;
        chk("cfg_hold_baud2", 32'(baudrate), 32'h0);
        chk("cfg_hold_ctrl", 32'(control), 32'h0);
        tx_empty  = 1'b1;
        req_valid = 4'b1000;
        #1;
        chk("cfg_drain_ready", 32'(req_ready), 32'h0);
        tick();
        chk("cfg_idle_busy", 32'(busy), 32'h0);
        chk("cfg_idle_noready", 32'(req_ready), 32'h0);
        chk("cfg_idle_baud_old", 32'(baudrate), 32'h0);
        tick();
        chk("cfg_baud", 32'(baudrate), 32'h0145);
        chk("cfg_ctrl", 32'(control), 32'h81);
        chk("cfg_then_ready", 32'(req_ready), 32'h8);
        tick();
        chk("cfg_then_write", 32'(write_tx), 32'h1);
        chk("cfg_then_txdata", 32'(txdata), 32'h44);
        req_valid = 4'b0000;
        $display("step cfg-drain: baud 0145 ctrl 81 applied in idle");

        // Asynchronous reset in the middle of GUARD.
        tick();
        chk("rst_mid_guard_busy", 32'(busy), 32'h1);
        req_valid = 4'b1111;
        #1;
        rst_n = 1'b0;
        #1;
        chk("arst_busy", 32'(busy), 32'h0);
        chk("arst_write", 32'(write_tx), 32'h0);
        chk("arst_txdata", 32'(txdata), 32'h0);
        chk("arst_baud", 32'(baudrate), 32'h0);
        chk("arst_ctrl", 32'(control), 32'h0);
        chk("arst_owner", 32'(rx_owner), 32'h0);
        chk("arst_rxbyte", 32'(rx_byte), 32'h0);
        chk("arst_ready", 32'(req_ready), 32'h0);
        tick();
        chk("arst_hold_write", 32'(write_tx), 32'h0);
        rst_n = 1'b1;
        #1;
        chk("arst_first_ready", 32'(req_ready), 32'h1);
        tick();
        chk("arst_first_write", 32'(write_tx), 32'h1);
        chk("arst_first_txdata", 32'(txdata), 32'h11);
        req_valid = 4'b0000;
        $display("step reset-mid-guard: requester 0 first after release");

        // Config and request together in IDLE: config first, grant next cycle.
        tick();
        tick();
        tick();
        tick();
        chk("cg_idle", 32'(busy), 32'h0);
        cfg_load  = 1'b1;
        baud_cfg  = 16'h0A0B;
        ctrl_cfg  = 8'h5A;
        req_valid = 4'b0001;
        #1;
        chk("cg_noready", 32'(req_ready), 32'h0);
        tick();
        cfg_load = 1'b0;
        #1;
        chk("cg_baud", 32'(baudrate), 32'h0A0B);
        chk("cg_ctrl", 32'(control), 32'h5A);
        chk("cg_ready", 32'(req_ready), 32'h1);
        tick();
        chk("cg_write", 32'(write_tx), 32'h1);
        chk("cg_txdata", 32'(txdata), 32'h11);
        req_valid = 4'b0000;
        $display("step cfg-vs-grant: config then grant 0");

        // Withdrawn request while the transmitter is not ready leaves no trace.
        tick();
        tick();
        tick();
        tick();
        tx_empty  = 1'b0;
        req_valid = 4'b0100;
        tick();
        chk("wd_busy", 32'(busy), 32'h0);
        chk("wd_ready", 32'(req_ready), 32'h0);
        req_valid = 4'b0000;
        tick();
        tx_empty = 1'b1;
        #1;
        chk("wd_ready_after", 32'(req_ready), 32'h0);
        tick();
        chk("wd_busy_after", 32'(busy), 32'h0);
        chk("wd_write_after", 32'(write_tx), 32'h0);
        chk("wd_txdata", 32'(txdata), 32'h11);
        $display("step withdraw: no grant issued");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_sched.md
UART_SCHED -- requirements
Module: uart_sched

Interface
REQ-001 Parameter: NREQ, 4, number of transmit requesters (fixed at 4 in this revision; width rules below assume 4).
REQ-002 Parameter: GUARD, 2, cycles after write_tx during which tx_empty is ignored.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 req_valid  input  4  per-requester byte-pending flag; bit i belongs to requester i.
REQ-006 req_data  input  32  per-requester byte; requester i owns bits [8i+7:8i].
REQ-007 req_ready  output  4  one-hot acceptance pulse; byte of requester i taken when req_valid[i] and req_ready[i] are both 1.
REQ-008 tx_empty  input  1  UART transmitter idle and able to take a byte.
REQ-009 txdata  output  8  byte presented to the UART.
REQ-010 write_tx  output  1  one-cycle load strobe to the UART.
REQ-011 rx_valid  input  1  UART holds a received byte.
REQ-012 rxdata  input  8  received byte from the UART.
REQ-013 read_rx  output  1  one-cycle pop strobe to the UART.
REQ-014 rx_byte  output  8  last received byte, held until the next reception.
REQ-015 rx_strobe  output  1  one-cycle pulse; rx_byte and rx_owner updated this cycle.
REQ-016 rx_owner  output  2  index of the requester most recently granted.
REQ-017 cfg_load  input  1  request to apply baud_cfg/ctrl_cfg.
REQ-018 baud_cfg  input  16  new baud divisor.
REQ-019 ctrl_cfg  input  8  new control byte.
REQ-020 baudrate  output  16  registered divisor driven to the UART.
REQ-021 control  output  8  registered control byte driven to the UART.
REQ-022 busy  output  1  high whenever FSM is not IDLE.

Function
REQ-023 TX FSM states SHALL be IDLE, WRITE, GUARD and DRAIN.
REQ-024 IDLE: when tx_empty=1, any req_valid set and no config pending, the FSM SHALL grant one requester: req_ready=1 for it for exactly that cycle, its byte latched into txdata, rx_owner set, next state WRITE.
REQ-025 Grant SHALL be round-robin: search starts at (last_grant+1) mod 4; last_grant resets to 3, so requester 0 wins first.
REQ-026 WRITE: write_tx=1 for exactly one cycle with txdata stable; next state GUARD with guard counter loaded to GUARD.
REQ-027 GUARD: counter decrements each cycle, tx_empty ignored; at zero, go to DRAIN.
REQ-028 DRAIN: stay until tx_empty=1, then return to IDLE; the next grant occurs no earlier than the cycle after re-entering IDLE.
REQ-029 Minimum spacing between write_tx pulses SHALL be GUARD+3 cycles.
REQ-030 txdata SHALL hold its value outside grant cycles; req_ready SHALL be 0 in all non-IDLE states.
REQ-031 Deasserting req_valid[i] in IDLE before grant SHALL withdraw the request with no side effect.
REQ-032 RX: when rx_valid=1 and read_rx was 0 last cycle, the block SHALL pulse read_rx and rx_strobe together for one cycle and load rx_byte=rxdata; RX SHALL operate independently of the TX FSM state.
REQ-033 rx_valid held high SHALL yield at most one read_rx every 2 cycles.
REQ-034 cfg_load=1 SHALL set a pending flag. The pending config SHALL be applied (baudrate<=baud_cfg, control<=ctrl_cfg) in the first IDLE cycle with the flag set, and the flag cleared. No grant SHALL occur in that cycle.
REQ-035 A cfg_load arriving while a config is already pending SHALL replace it; the last values win.
REQ-036 Simultaneous cfg_load and grant opportunity in IDLE: config wins and is applied; the grant happens in the next cycle.

Reset
REQ-037 rst_n=0 SHALL immediately force: FSM=IDLE, req_ready=0, write_tx=0, read_rx=0, rx_strobe=0, txdata=0, rx_byte=0, rx_owner=0, last_grant=3, baudrate=0, control=0, config pending cleared, busy=0.
REQ-038 Reset during WRITE/GUARD/DRAIN SHALL abort the transfer with no further write_tx; after release, the FSM starts from IDLE.

Verification
REQ-039 req_valid=4'b1111, tx_empty=1 constant, GUARD=2 -> grants 0,1,2,3,0 in order; write_tx pulses exactly 5 cycles apart; txdata matches each owner's byte.
REQ-040 req_valid[2]=1 with data 0xA5, tx_empty low for 10 cycles after write -> a single write_tx with txdata=0xA5; busy high until tx_empty returns, then IDLE.
REQ-041 rx_valid=1 with rxdata=0x3C for 6 cycles, last grant=1 -> read_rx pulses at cycles 0,2,4; rx_byte=0x3C, rx_owner=1.
REQ-042 cfg_load with baud_cfg=0x0145, ctrl_cfg=0x81 during DRAIN -> outputs unchanged until IDLE, then updated in one cycle with no grant in that cycle.
REQ-043 rst_n low mid-GUARD -> all outputs at reset values asynchronously; after release, requester 0 is granted first.
REQ-044 cfg_load and req_valid[0] both asserted in IDLE -> config applied first; grant to requester 0 the following cycle.
